// File: rtl/io_port_pkg.sv
// Address map and constants shared by the port responder and its timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package io_port_pkg;
    localparam logic [4:0] ADDR_OUT0    = 5'h00;
    localparam logic [4:0] ADDR_OUT1    = 5'h01;
    localparam logic [4:0] ADDR_OUT2    = 5'h02;
    localparam logic [4:0] ADDR_OUT3    = 5'h03;
    localparam logic [4:0] ADDR_IN0     = 5'h04;
    localparam logic [4:0] ADDR_IN1     = 5'h05;
    localparam logic [4:0] ADDR_IN2     = 5'h06;
    localparam logic [4:0] ADDR_IN3     = 5'h07;
    localparam logic [4:0] ADDR_EVENT   = 5'h08;
    localparam logic [4:0] ADDR_TCOUNT  = 5'h09;
    localparam logic [4:0] ADDR_TCMP    = 5'h0A;
    localparam logic [4:0] ADDR_STATUS  = 5'h0B;
    localparam logic [4:0] ADDR_IRQMASK = 5'h0C;

    localparam int STATUS_MATCH_BIT = 0;
    localparam int STATUS_EVT_BIT   = 1;

    localparam logic [15:0] TCMP_RESET = 16'hFFFF;
endpackage

// File: rtl/io_port_timer.sv
// Prescaled 16-bit tick counter with a compare register and sticky MATCH flag.
// Latency: all outputs registered; MATCH sets on the edge TCOUNT steps onto TCMP.
// Backpressure: none; control strobes are single-cycle and always accepted.
module io_port_timer
    import io_port_pkg::*;
#(
    parameter logic [15:0] PRESCALE = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr_count,
    input  logic        wr_cmp,
    input  logic [15:0] cmp_data,
    input  logic        clr_match,
    output logic [15:0] count,
    output logic [15:0] cmp,
    output logic        match
);
    logic [15:0] r_presc;
    logic [15:0] r_count;
    logic [15:0] r_cmp;
    logic        r_match;
    logic        w_tick;
    logic [15:0] w_count_inc;

    assign w_tick      = (r_presc == PRESCALE - 16'd1);
    assign w_count_inc = r_count + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= '0;
            r_count <= '0;
            r_cmp   <= TCMP_RESET;
            r_match <= 1'b0;
        end else begin
            if (clr_count) begin
                r_presc <= '0;
                r_count <= '0;
            end else if (w_tick) begin
                r_presc <= '0;
                r_count <= w_count_inc;
            end else begin
                r_presc <= r_presc + 16'd1;
            end
            if (wr_cmp) r_cmp <= cmp_data;
            // Only an actual increment can set MATCH; a cleared counter never does.
            r_match <= (r_match & ~clr_match) |
                       (w_tick & ~clr_count & (w_count_inc == r_cmp));
        end
    end

    assign count = r_count;
    assign cmp   = r_cmp;
    assign match = r_match;
endmodule

// File: rtl/io_port_responder.sv
// Port-bus responder: OUT regs, synced IN ports, EVENT capture, timer; IO_PORT_IRQ_EN adds IRQMASK/irq.
// Latency: read data combinational (0 cycles); writes commit on the we edge; IN lags pins by SYNC_STAGES.
// Backpressure: none; every access completes in the cycle it is presented.
module io_port_responder
    import io_port_pkg::*;
#(
    parameter logic [15:0] PRESCALE    = 16'd50000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  dirport,
    input  logic [15:0] outport,
    input  logic        we,
    output logic [15:0] inport,
    input  logic [63:0] in_pins,
    output logic [63:0] out_pins
`ifdef IO_PORT_IRQ_EN
    ,
    output logic        irq
`endif
);
    logic [3:0][15:0] r_out;
    logic [63:0]      r_sync [SYNC_STAGES];
    logic [15:0]      r_in0_prev;
    logic [15:0]      r_event;
    logic [63:0]      w_in;
    logic [15:0]      w_edge;
    logic [15:0]      w_count;
    logic [15:0]      w_cmp;
    logic             w_match;
    logic [15:0]      w_status;
    logic             w_wr_event;
    logic             w_wr_status;

    assign w_in        = r_sync[SYNC_STAGES-1];
    assign w_edge      = w_in[15:0] & ~r_in0_prev;
    assign w_wr_event  = we && (dirport == ADDR_EVENT);
    assign w_wr_status = we && (dirport == ADDR_STATUS);
    assign w_status    = {14'd0, |r_event, w_match};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out      <= '0;
            r_in0_prev <= '0;
            r_event    <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            if (we && (dirport <= ADDR_OUT3)) r_out[dirport[1:0]] <= outport;
            r_sync[0] <= in_pins;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_in0_prev <= w_in[15:0];
            // A fresh edge survives a W1C of the same bit in the same cycle.
            r_event <= (r_event & ~(w_wr_event ? outport : 16'd0)) | w_edge;
        end
    end

    io_port_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_count (we && (dirport == ADDR_TCOUNT)),
        .wr_cmp    (we && (dirport == ADDR_TCMP)),
        .cmp_data  (outport),
        .clr_match (w_wr_status && outport[STATUS_MATCH_BIT]),
        .count     (w_count),
        .cmp       (w_cmp),
        .match     (w_match)
    );

`ifdef IO_PORT_IRQ_EN
    logic [1:0] r_irqmask;
    logic       r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqmask <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (we && (dirport == ADDR_IRQMASK)) r_irqmask <= outport[1:0];
            r_irq <= |(w_status[1:0] & r_irqmask);
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        inport = 16'h0000;
        case (dirport)
            ADDR_OUT0, ADDR_OUT1, ADDR_OUT2, ADDR_OUT3: inport = r_out[dirport[1:0]];
            ADDR_IN0, ADDR_IN1, ADDR_IN2, ADDR_IN3:     inport = w_in[{dirport[1:0], 4'b0000} +: 16];
            ADDR_EVENT:   inport = r_event;
            ADDR_TCOUNT:  inport = w_count;
            ADDR_TCMP:    inport = w_cmp;
            ADDR_STATUS:  inport = w_status;
`ifdef IO_PORT_IRQ_EN
            ADDR_IRQMASK: inport = {14'd0, r_irqmask};
`endif
            default:      inport = 16'h0000;
        endcase
    end

    assign out_pins = r_out;
endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Peripheral-side responder for the processor's 5-bit port bus (`dirport` / `outport` / `we` / `inport`).
- Decodes the port address and latches write data into output registers.
- Returns read data on `inport` in the same cycle. The processor's memory/IO mux samples `inport` combinationally.
- Adds synchronized input ports, sticky edge-event capture, and a prescaled timer with a compare flag, so programs can poll I/O and time events.

Parameters:
- PRESCALE, 16'd50000: clock cycles per timer tick; legal range 1..65535.
- SYNC_STAGES, 2: flip-flop stages on the `in_pins` synchronizer; minimum 2.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `dirport` input 5: port address from the processor.
- `outport` input 16: write data from the processor.
- `we` input 1: write strobe; the write commits at the rising edge where `we`=1.
- `inport` output 16: read data to the processor; combinational function of `dirport` and registered state.
- `in_pins` input 64: external asynchronous inputs, 4 x 16 bits.
- `out_pins` output 64: external outputs, `{OUT3,OUT2,OUT1,OUT0}`.

Behaviour:
- Address map (hex):
  - 00-03 OUT0-3: R/W.
  - 04-07 IN0-3: RO, synchronized `in_pins`; writes ignored.
  - 08 EVENT: sticky rising edges of synchronized IN0, write-1-to-clear.
  - 09 TCOUNT: RO; any write clears it to 0.
  - 0A TCMP: R/W.
  - 0B STATUS: bit0 MATCH (W1C); bit1 EVT_ANY = |EVENT (read-only); bits 15:2 read 0.
  - 0C IRQMASK: present only with the optional feature.
  - All other addresses read 16'h0000; writes to them are ignored.
- Reset values:
  - OUT0-3 = 0; `out_pins` = 0.
  - EVENT = 0, TCOUNT = 0, TCMP = 16'hFFFF, MATCH = 0, prescaler = 0.
  - Synchronizer flops = 0, so a high input sampled after reset appears as a rising edge.
- Read latency: 0 cycles. `inport` reflects the addressed register's value before any edge in progress. A read-after-write to the same address shows new data the following cycle.
- Write: `outport` captured on the edge with `we`=1; no wait states, no handshake.
- Input path: IN lag `in_pins` by SYNC_STAGES cycles.
  - Edge = sync & ~sync_prev on IN0, bitwise.
  - EVENT next = (EVENT & ~w1c_mask) | edge. Set wins over a same-cycle clear of the same bit.
- Timer:
  - Prescaler counts 0..PRESCALE-1. At the terminal count it wraps to 0 and TCOUNT increments.
  - TCOUNT wraps FFFF->0000.
  - A write to 09 clears both TCOUNT and the prescaler; clear wins over a same-cycle increment.
- Compare:
  - MATCH sets on the cycle TCOUNT transitions to a value equal to TCMP, i.e. once per increment, not level-held.
  - Set wins over a same-cycle W1C of bit0.
  - Writing TCMP equal to the current TCOUNT does not set MATCH.
- `reset` asserted mid-operation: every register returns to its reset value at that edge. A `we` in the same cycle is discarded.
- Outputs drive directly from registers; no combinational path from `in_pins` to `out_pins`.

Optional Feature:
- Macro: `IO_PORT_IRQ_EN`.
- Defined:
  - Adds output `irq` (1 bit) = |(STATUS[1:0] & IRQMASK[1:0]), registered, 1-cycle latency.
  - Adds IRQMASK at address 0C: R/W, bits 1:0, reset 0.
- Undefined: no `irq` port; 0C reads 0 and writes are ignored.

Decomposition:
- Package `io_port_pkg`: 5-bit address constants (`ADDR_OUT0`..`ADDR_IRQMASK`), STATUS bit indices, TCMP reset value.
- Sub-module `io_port_timer`:
  - Contains the prescaler, TCOUNT, compare and MATCH.
  - Inputs: `clr_count`, `wr_cmp`/`cmp_data`, `clr_match`.
  - Outputs: `count`, `cmp`, `match`.
- Address decode, synchronizer, EVENT logic and read mux stay in the top level.

Test Plan:
- Reset, then write 16'hA5A5 to 01 and read 01 -> `inport`=A5A5 the next cycle; `out_pins[31:16]`=A5A5. Read 1F -> 0000.
- Drive `in_pins[15:0]` 0000->0005 -> IN0 reads 0005 after SYNC_STAGES cycles; EVENT=0005; STATUS bit1=1. Write 08 = 0001 -> EVENT=0004.
- Hold IN0 bit2 rising on the same edge as a W1C of bit2 -> EVENT bit2 stays 1.
- PRESCALE=4, TCMP=3, write 09 -> MATCH sets exactly 12 cycles later and stays set. Write 0B = 0001 -> cleared; TCOUNT continues to wrap past FFFF to 0000.
- Assert `reset` with `we`=1 to 00 = 1234 -> OUT0=0, TCMP=FFFF, `inport` at 0A = FFFF.
- With `IO_PORT_IRQ_EN` defined: IRQMASK=0001, reach MATCH -> `irq`=1 one cycle later. W1C MATCH -> `irq`=0 one cycle after the clear.
